// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / audio-out bundle of the time-multiplexed FIR; master drives samples, slave filters.
// No backpressure path: producer must respect busy or see the sample dropped and overrun flagged.
interface fir_mac_sequencer_if #(
    parameter int DW = 12
);
    logic          sample_stb;
    logic [DW-1:0] sample_in;
    logic          overrun_clr;
    logic [DW-1:0] audio_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    modport master (
        output sample_stb,
        output sample_in,
        output overrun_clr,
        input  audio_out,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample_stb,
        input  sample_in,
        input  overrun_clr,
        output audio_out,
        output out_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// 29-tap FIR on one shared MAC; result pulses out_valid 31 clocks after the accepted strobe.
// No stall: a strobe while busy is dropped and sets the sticky overrun flag.
module fir_mac_sequencer #(
    parameter int TAPS      = 29,
    parameter int DW        = 12,
    parameter int CW        = 12,
    parameter int AW        = 24,
    parameter int OUT_SHIFT = 12
) (
    input  logic                 clk,
    input  logic                 RSTn,
    fir_mac_sequencer_if.slave   bus
);
    localparam int PW = $clog2(TAPS);
    localparam int MW = DW + CW;

    localparam int unsigned COEFF_TBL [29] = '{
        48, 48, 50, 53, 56, 53, 42, 24, 10, 15, 52, 119, 199, 264, 290,
        264, 199, 119, 52, 15, 10, 24, 42, 53, 56, 53, 50, 48, 48
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tap_q, tap_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   audio_q, audio_d;
    logic            out_valid_q, out_valid_d;
    logic            overrun_q, overrun_d;
    logic [DW-1:0]   smp_q [TAPS];

    logic            wr_en;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   rd_idx;
    logic [CW-1:0]   coeff;
    logic [MW-1:0]   prod;

    assign nxt_ptr = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + PW'(1);

    // Modulo-2^PW arithmetic still lands in 0..TAPS-1 because the true result does.
    always_comb begin
        if (wr_ptr_q >= tap_q) begin
            rd_idx = wr_ptr_q - tap_q;
        end else begin
            rd_idx = wr_ptr_q + PW'(TAPS) - tap_q;
        end
    end

    assign coeff = CW'(COEFF_TBL[tap_q]);
    assign prod  = MW'(smp_q[rd_idx]) * MW'(coeff);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        audio_d     = audio_q;
        out_valid_d = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sample_stb) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = nxt_ptr;
                    acc_d    = '0;
                    tap_d    = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod);
                if (tap_q == PW'(TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    tap_d = tap_q + PW'(1);
                end
            end
            ST_DONE: begin
                audio_d     = acc_q[AW-1:OUT_SHIFT];
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (bus.sample_stb && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q    <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            audio_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            audio_q     <= audio_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < TAPS; i++) begin
                smp_q[i] <= '0;
            end
        end else if (wr_en) begin
            smp_q[nxt_ptr] <= bus.sample_in;
        end
    end

    assign bus.audio_out = audio_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reset, impulse, DC, overrun, wrap and mid-MAC reset.
module tb_fir_mac_sequencer;
    logic clk  = 1'b0;
    logic RSTn = 1'b0;

    fir_mac_sequencer_if #(.DW(12)) ifc ();

    fir_mac_sequencer dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int coef [29] = '{48, 48, 50, 53, 56, 53, 42, 24, 10, 15, 52, 119, 199, 264, 290,
                      264, 199, 119, 52, 15, 10, 24, 42, 53, 56, 53, 50, 48, 48};
    int imp_exp [29] = '{47, 47, 49, 52, 55, 52, 41, 23, 9, 14, 51, 118, 198, 263, 289,
                         263, 198, 118, 51, 14, 9, 23, 41, 52, 55, 52, 49, 47, 47};
    int hist [29];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 29; i++) hist[i] = 0;
    endtask

    task automatic model_push(input int v);
        for (int i = 28; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endtask

    function automatic int model_out();
        int s;
        s = 0;
        for (int k = 0; k < 29; k++) s += coef[k] * hist[k];
        return (s % (1 << 24)) >> 12;
    endfunction

    // Caller sits at a negedge; returns at the first negedge after the strobe edge.
    task automatic start(input int v);
        ifc.sample_stb = 1'b1;
        ifc.sample_in  = 12'(v);
        @(posedge clk);
        @(negedge clk);
        ifc.sample_stb = 1'b0;
    endtask

    // k0 = negedges already elapsed since the strobe edge; lat = 0 on timeout.
    task automatic wait_valid(input int k0, output int lat);
        lat = 0;
        for (int k = k0; k <= 45; k++) begin
            if (k > k0) @(negedge clk);
            if (ifc.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic xfer(input int v, input int expv, input string tag);
        int lat;
        start(v);
        wait_valid(1, lat);
        chk({tag, "_lat"}, lat, 31);
        chk({tag, "_val"}, ifc.audio_out, expv);
        chk({tag, "_busy"}, ifc.busy, 0);
    endtask

    initial begin
        int lat;
        int seen;
        ifc.sample_stb  = 1'b0;
        ifc.sample_in   = '0;
        ifc.overrun_clr = 1'b0;
        model_clear();

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_audio", ifc.audio_out, 0);
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_overrun", ifc.overrun, 0);
        RSTn = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b0) seen++;
        end
        chk("idle_valid_cnt", seen, 0);
        chk("idle_audio", ifc.audio_out, 0);
        chk("idle_busy", ifc.busy, 0);
        chk("idle_overrun", ifc.overrun, 0);

        // Impulse at 40-clock spacing
        for (int i = 0; i < 29; i++) begin
            int v;
            v = (i == 0) ? 4095 : 0;
            model_push(v);
            xfer(v, imp_exp[i], $sformatf("imp%0d", i));
            repeat (9) @(negedge clk);
        end

        // DC at minimum spacing
        for (int i = 0; i < 40; i++) begin
            model_push(4095);
            xfer(4095, (i >= 28) ? 2355 : model_out(), $sformatf("dc%0d", i));
        end
        chk("dc_overrun", ifc.overrun, 0);
        repeat (5) @(negedge clk);

        // Overrun: second strobe 10 clocks into the first sample
        model_push(1000);
        start(1000);
        repeat (9) @(negedge clk);
        ifc.sample_stb = 1'b1;
        ifc.sample_in  = 12'd4095;
        @(negedge clk);
        ifc.sample_stb = 1'b0;
        chk("ovr_set", ifc.overrun, 1);
        wait_valid(11, lat);
        chk("ovr_lat", lat, 31);
        chk("ovr_val", ifc.audio_out, model_out());
        ifc.overrun_clr = 1'b1;
        @(negedge clk);
        ifc.overrun_clr = 1'b0;
        chk("ovr_clr", ifc.overrun, 0);

        // Drop and clear in the same cycle: set wins
        model_push(5);
        start(5);
        repeat (4) @(negedge clk);
        ifc.sample_stb  = 1'b1;
        ifc.sample_in   = 12'd4095;
        ifc.overrun_clr = 1'b1;
        @(negedge clk);
        ifc.sample_stb  = 1'b0;
        ifc.overrun_clr = 1'b0;
        chk("ovr_both", ifc.overrun, 1);
        wait_valid(6, lat);
        chk("ovr2_lat", lat, 31);
        chk("ovr2_val", ifc.audio_out, model_out());
        ifc.overrun_clr = 1'b1;
        @(negedge clk);
        ifc.overrun_clr = 1'b0;
        chk("ovr_clr2", ifc.overrun, 0);

        // Ramp across the write-pointer wrap
        for (int i = 1; i <= 60; i++) begin
            model_push(i);
            xfer(i, model_out(), $sformatf("ramp%0d", i));
        end

        // Reset during tap 15
        start(4095);
        repeat (15) @(negedge clk);
        RSTn = 1'b0;
        @(negedge clk);
        RSTn = 1'b1;
        model_clear();
        chk("mrst_busy", ifc.busy, 0);
        chk("mrst_audio", ifc.audio_out, 0);
        chk("mrst_valid", ifc.out_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b0) seen++;
        end
        chk("mrst_valid_cnt", seen, 0);
        for (int i = 0; i < 29; i++) begin
            int v;
            v = (i == 0) ? 4095 : 0;
            xfer(v, imp_exp[i], $sformatf("imp2_%0d", i));
            repeat (9) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
